max_pool_layer_1: RTL

- 2x2, stride-2 max-pooling stage directly downstream of the first convolution layer.
- Consumes the six clamped-ReLU channel outputs (q8.24, range 0..0x01000000), one pixel per valid strobe, in raster order of the 24x24 conv output map.
- Produces six pooled 12x12 maps in raster order for the next convolution layer.
- Uses a half-width line buffer, so no full-frame storage is needed.

---
 rtl/max_pool_layer_1_if.sv | 19 +
 rtl/max_pool_layer_1.sv | 104 ++++++++++
 2 files changed

// File: rtl/max_pool_layer_1_if.sv
// Pixel-in / pooled-result-out bundle between conv layer 1, the max-pool stage and conv layer 2.
// No backpressure: valid_input and valid_output are single-cycle qualifiers.
interface max_pool_layer_1_if #(parameter int data_bits = 32);
   logic [data_bits-1:0] in1, in2, in3, in4, in5, in6;
   logic                 valid_input;
   logic [data_bits-1:0] out1, out2, out3, out4, out5, out6;
   logic                 valid_output;
   logic                 finish;

   modport master (
      output in1, in2, in3, in4, in5, in6, valid_input,
      input  out1, out2, out3, out4, out5, out6, valid_output, finish
   );

   modport slave (
      input  in1, in2, in3, in4, in5, in6, valid_input,
      output out1, out2, out3, out4, out5, out6, valid_output, finish
   );
endinterface

// File: rtl/max_pool_layer_1.sv
// 2x2 stride-2 max pool over six channels, streaming in raster order with a half-width line buffer.
// Result registered 1 clock after each odd-row/odd-col pixel; no backpressure, idles in DONE until reset.
module max_pool_layer_1 #(
   parameter int data_bits = 32,
   parameter int in_width  = 24,
   parameter int in_height = 24
) (
   input logic              clk_global,
   input logic              reset_layer,
   max_pool_layer_1_if.slave bus
);
   localparam int NCH  = 6;
   localparam int HALF = in_width / 2;
   localparam int NOUT = HALF * (in_height / 2);
   localparam int CW   = $clog2(in_width);
   localparam int RW   = $clog2(in_height);
   localparam int OW   = $clog2(NOUT + 1);

   typedef enum logic {ST_ACTIVE, ST_DONE} state_t;

   state_t               r_state, w_state_nxt;
   logic [CW-1:0]        r_col;
   logic [RW-1:0]        r_row;
   logic [OW-1:0]        r_cnt;
   logic [data_bits-1:0] r_hold [NCH];
   logic [data_bits-1:0] r_lbuf [NCH][HALF];
   logic [data_bits-1:0] r_out  [NCH];
   logic                 r_vld;

   logic [data_bits-1:0] w_in [NCH];
   logic                 w_accept;
   logic                 w_emit;
   logic [CW-2:0]        w_idx;

   function automatic logic [data_bits-1:0] max2(input logic [data_bits-1:0] a,
                                                 input logic [data_bits-1:0] b);
      return (a > b) ? a : b;
   endfunction

   assign w_in[0] = bus.in1;
   assign w_in[1] = bus.in2;
   assign w_in[2] = bus.in3;
   assign w_in[3] = bus.in4;
   assign w_in[4] = bus.in5;
   assign w_in[5] = bus.in6;

   assign w_accept = bus.valid_input && (r_state == ST_ACTIVE);
   assign w_emit   = w_accept && r_row[0] && r_col[0];
   assign w_idx    = r_col[CW-1:1];

   always_comb begin
      w_state_nxt = r_state;
      if (w_emit && (r_cnt == OW'(NOUT - 1)))
         w_state_nxt = ST_DONE;
   end

   always_ff @(posedge clk_global) begin
      if (reset_layer) begin
         r_state <= ST_ACTIVE;
         r_col   <= '0;
         r_row   <= '0;
         r_cnt   <= '0;
         r_vld   <= 1'b0;
         for (int c = 0; c < NCH; c++) r_out[c] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_vld   <= w_emit;
         if (w_accept) begin
            if (r_col == CW'(in_width - 1)) begin
               r_col <= '0;
               r_row <= (r_row == RW'(in_height - 1)) ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end
         if (w_emit) begin
            r_cnt <= r_cnt + 1'b1;
            for (int c = 0; c < NCH; c++)
               r_out[c] <= max2(max2(r_hold[c], w_in[c]), r_lbuf[c][w_idx]);
         end
      end
   end

   // Pooling storage carries no reset: a frame always rewrites it before reading.
   always_ff @(posedge clk_global) begin
      if (!reset_layer && w_accept) begin
         for (int c = 0; c < NCH; c++) begin
            if (!r_col[0])
               r_hold[c] <= w_in[c];
            else if (!r_row[0])
               r_lbuf[c][w_idx] <= max2(r_hold[c], w_in[c]);
         end
      end
   end

   assign bus.out1         = r_out[0];
   assign bus.out2         = r_out[1];
   assign bus.out3         = r_out[2];
   assign bus.out4         = r_out[3];
   assign bus.out5         = r_out[4];
   assign bus.out6         = r_out[5];
   assign bus.valid_output = r_vld;
   assign bus.finish       = (r_state == ST_DONE);
endmodule
